// File: rtl/irq_sequencer.sv
`default_nettype none
// irq_sequencer: level/edge IRQ latch, mask, lowest-index priority and trap/vector/ack handshake with an in-service stack.
// Rev 1.0 -- define IRQ_SEQ_PREEMPT_EN for nested pre-emption up to NEST_DEPTH; otherwise one interrupt is in service at a time.
module irq_sequencer #(
    parameter int          NEST_DEPTH = 8,
    parameter logic [27:0] BASE       = 28'hffffffe
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        strobe,
    input  logic        rw,
    input  logic [31:0] addr,
    inout  wire  [31:0] data,
    input  logic [31:0] irq,
    output logic        trap,
    output logic [4:0]  vector,
    input  logic        ack
);

`ifdef IRQ_SEQ_PREEMPT_EN
    localparam int LIMIT = NEST_DEPTH;
`else
    localparam int LIMIT = 1;
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        BUSY_FULL = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] s_q, s_d, sp_q, sp_d;
    logic [31:0] pend_edge_q, pend_edge_d;
    logic [31:0] mask_q, mask_d, edge_sel_q, edge_sel_d;
    logic [31:0] rdata_q, rdata_d;
    logic [5:0]  depth_q, depth_d;
    logic [4:0]  stack_q [NEST_DEPTH];
    logic [4:0]  stack_d [NEST_DEPTH];
    logic        trap_q, trap_d;
    logic [4:0]  vector_q, vector_d;

    logic        sel, wr, eoi, push;
    logic [3:0]  off;
    logic [31:0] pend, above, cand, w1c, ack_clr;
    logic [4:0]  top, winner;
    logic [5:0]  popped;

    assign sel    = strobe && (addr[31:4] == BASE);
    assign wr     = sel && rw;
    assign off    = addr[3:0];
    assign eoi    = wr && (off == 4'h3) && (depth_q != 6'd0);
    assign data   = (strobe && !rw) ? rdata_q : 32'bz;
    assign trap   = trap_q;
    assign vector = vector_q;

    always_comb begin
        s_d  = irq;
        sp_d = s_q;

        top = 5'd0;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            if (depth_q == 6'(i + 1)) top = stack_q[i];
        end

        pend = (edge_sel_q & pend_edge_q) | (~edge_sel_q & s_q);

        // Only strictly higher-priority (lower index) lines may pre-empt the one in service.
`ifdef IRQ_SEQ_PREEMPT_EN
        above = (depth_q == 6'd0) ? 32'hffff_ffff : ((32'd1 << top) - 32'd1);
`else
        above = (depth_q == 6'd0) ? 32'hffff_ffff : 32'd0;
`endif
        cand = pend & mask_q & above;

        winner = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (cand[i]) winner = 5'(i);
        end

        // EOI pops before an ack in the same cycle pushes.
        push    = (state_q == REQ) && ack;
        popped  = eoi ? depth_q - 6'd1 : depth_q;
        depth_d = push ? popped + 6'd1 : popped;
        for (int i = 0; i < NEST_DEPTH; i++) begin
            stack_d[i] = (push && popped == 6'(i)) ? vector_q : stack_q[i];
        end

        w1c         = (wr && off == 4'h0) ? data : 32'd0;
        ack_clr     = push ? (32'd1 << vector_q) : 32'd0;
        pend_edge_d = (pend_edge_q & ~w1c & ~ack_clr) | (s_q & ~sp_q & edge_sel_q);
        mask_d      = (wr && off == 4'h1) ? data : mask_q;
        edge_sel_d  = (wr && off == 4'h2) ? data : edge_sel_q;

        state_d  = state_q;
        trap_d   = trap_q;
        vector_d = vector_q;
        case (state_q)
            IDLE: begin
                if (depth_q == 6'(LIMIT) && !eoi) begin
                    state_d = BUSY_FULL;
                end else if (cand != 32'd0) begin
                    state_d  = REQ;
                    trap_d   = 1'b1;
                    vector_d = winner;
                end
            end
            REQ: begin
                if (ack || cand == 32'd0) begin
                    state_d = IDLE;
                    trap_d  = 1'b0;
                end else begin
                    vector_d = winner;
                end
            end
            BUSY_FULL: begin
                if (eoi) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                trap_d  = 1'b0;
            end
        endcase

        rdata_d = rdata_q;
        if (sel && !rw) begin
            case (off)
                4'h0:    rdata_d = pend;
                4'h1:    rdata_d = mask_q;
                4'h2:    rdata_d = edge_sel_q;
                4'h3:    rdata_d = {depth_q != 6'd0, 26'd0, top};
                4'h4:    rdata_d = {26'd0, depth_q};
                default: rdata_d = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            s_q         <= 32'd0;
            sp_q        <= 32'd0;
            pend_edge_q <= 32'd0;
            mask_q      <= 32'd0;
            edge_sel_q  <= 32'd0;
            rdata_q     <= 32'd0;
            depth_q     <= 6'd0;
            trap_q      <= 1'b0;
            vector_q    <= 5'd0;
            for (int i = 0; i < NEST_DEPTH; i++) stack_q[i] <= 5'd0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            sp_q        <= sp_d;
            pend_edge_q <= pend_edge_d;
            mask_q      <= mask_d;
            edge_sel_q  <= edge_sel_d;
            rdata_q     <= rdata_d;
            depth_q     <= depth_d;
            trap_q      <= trap_d;
            vector_q    <= vector_d;
            for (int i = 0; i < NEST_DEPTH; i++) stack_q[i] <= stack_d[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_irq_sequencer.sv
`default_nettype none
// tb_irq_sequencer: directed scoreboard bench for irq_sequencer (NEST_DEPTH=2); covers both IRQ_SEQ_PREEMPT_EN builds.
module tb_irq_sequencer;

    localparam logic [27:0] BASE = 28'hffffffe;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        strobe = 1'b0;
    logic        rw = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] irq = 32'd0;
    logic        ack = 1'b0;
    logic        drv = 1'b0;
    logic [31:0] wdata = 32'd0;
    wire  [31:0] data;
    logic        trap;
    logic [4:0]  vector;

    int vectors = 0;
    int miscompares = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    assign data = drv ? wdata : 32'bz;

    always #5 clk = ~clk;

    irq_sequencer #(.NEST_DEPTH(2), .BASE(BASE)) dut (
        .clk(clk), .reset_n(reset_n), .strobe(strobe), .rw(rw), .addr(addr),
        .data(data), .irq(irq), .trap(trap), .vector(vector), .ack(ack)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty observed=%h", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
        expect_val(tag, e);
        check(obs);
    endtask

    task automatic chk_trap(input string tag, input logic t, input logic [4:0] v);
        chk({tag, "_trap"}, {31'd0, trap}, {31'd0, t});
        if (t) chk({tag, "_vector"}, {27'd0, vector}, {27'd0, v});
    endtask

    task automatic wr(input logic [3:0] off, input logic [31:0] v);
        strobe = 1'b1; rw = 1'b1; addr = {BASE, off}; wdata = v; drv = 1'b1;
        tick();
        strobe = 1'b0; rw = 1'b0; drv = 1'b0;
    endtask

    task automatic rd(input logic [3:0] off, input string tag, input logic [31:0] e);
        strobe = 1'b1; rw = 1'b0; addr = {BASE, off};
        expect_val(tag, e);
        tick();
        check(data);
        strobe = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        tick(); tick();
        reset_n = 1'b1;
        chk_trap("reset", 1'b0, 5'd0);
        chk("reset_vector", {27'd0, vector}, 32'd0);
        rd(4'h4, "reset_depth", 32'd0);
        rd(4'h1, "reset_mask", 32'd0);

        // Basic edge trap on line 0
        wr(4'h1, 32'h1);
        wr(4'h2, 32'h1);
        irq = 32'h1; tick(); irq = 32'h0;
        tick(); chk_trap("edge_early", 1'b0, 5'd0);
        tick(); chk_trap("edge_trap", 1'b1, 5'd0);
        do_ack(); chk_trap("edge_acked", 1'b0, 5'd0);
        rd(4'h0, "edge_pend_after_ack", 32'h0);
        rd(4'h4, "edge_depth_after_ack", 32'd1);
        rd(4'h3, "edge_isv", 32'h8000_0000);
        wr(4'h3, 32'h0);
        rd(4'h4, "edge_depth_after_eoi", 32'd0);

        // W1C coincident with a new edge: set wins
        wr(4'h1, 32'h0);
        irq = 32'h1; tick();
        wr(4'h0, 32'h1);
        rd(4'h0, "w1c_vs_set", 32'h1);
        wr(4'h0, 32'h1);
        rd(4'h0, "w1c_alone", 32'h0);
        irq = 32'h0;

        // Priority and re-tracking on level lines
        wr(4'h2, 32'h0);
        wr(4'h1, 32'hffff_ffff);
        irq = 32'h20; tick(); tick();
        chk_trap("prio_first", 1'b1, 5'd5);
        irq = 32'h24; tick(); tick();
        chk_trap("prio_retrack", 1'b1, 5'd2);
        do_ack(); chk_trap("prio_acked", 1'b0, 5'd0);
        rd(4'h3, "prio_isv", 32'h8000_0002);
        irq = 32'h0; tick();
        wr(4'h3, 32'h0);
        rd(4'h4, "prio_depth_after_eoi", 32'd0);

        // EOI with nothing in service
        wr(4'h3, 32'h0);
        rd(4'h4, "eoi_at_zero_depth", 32'd0);
        rd(4'h3, "eoi_at_zero_isv", 32'h0);

`ifdef IRQ_SEQ_PREEMPT_EN
        // Pre-emption: 4 in service, 1 pre-empts, 7 waits for two EOIs
        irq = 32'h10; tick(); tick();
        chk_trap("pre_first", 1'b1, 5'd4);
        do_ack(); chk_trap("pre_first_acked", 1'b0, 5'd0);
        irq = 32'h12; tick(); tick();
        chk_trap("pre_second", 1'b1, 5'd1);
        do_ack();
        rd(4'h4, "pre_depth2", 32'd2);
        irq = 32'h80; tick(); tick(); tick();
        chk_trap("pre_blocked", 1'b0, 5'd0);
        wr(4'h3, 32'h0); tick(); tick();
        chk_trap("pre_one_eoi", 1'b0, 5'd0);
        wr(4'h3, 32'h0);
        chk_trap("pre_two_eoi_same_edge", 1'b0, 5'd0);
        tick(); chk_trap("pre_two_eoi", 1'b1, 5'd7);
        do_ack(); irq = 32'h0; tick();
        wr(4'h3, 32'h0);
        rd(4'h4, "pre_depth_end", 32'd0);

        // Stack full at NEST_DEPTH=2
        irq = 32'h40; tick(); tick();
        chk_trap("full_first", 1'b1, 5'd6);
        do_ack();
        irq = 32'h48; tick(); tick();
        chk_trap("full_second", 1'b1, 5'd3);
        do_ack();
        irq = 32'h49; tick(); tick(); tick();
        chk_trap("full_blocked", 1'b0, 5'd0);
        rd(4'h4, "full_depth", 32'd2);
        irq = 32'h1; tick();
        wr(4'h3, 32'h0);
        chk_trap("full_eoi_same_edge", 1'b0, 5'd0);
        tick(); chk_trap("full_after_eoi", 1'b1, 5'd0);
        do_ack(); irq = 32'h0; tick();
        wr(4'h3, 32'h0);
        wr(4'h3, 32'h0);
        rd(4'h4, "full_depth_end", 32'd0);
`else
        // Single-level build: PEND accumulates while something is in service
        irq = 32'h10; tick(); tick();
        chk_trap("np_first", 1'b1, 5'd4);
        do_ack(); chk_trap("np_acked", 1'b0, 5'd0);
        irq = 32'h12; tick(); tick(); tick();
        chk_trap("np_blocked", 1'b0, 5'd0);
        rd(4'h0, "np_pend", 32'h12);
        rd(4'h4, "np_depth", 32'd1);
        irq = 32'h2; tick();
        wr(4'h3, 32'h0);
        chk_trap("np_eoi_same_edge", 1'b0, 5'd0);
        tick(); chk_trap("np_after_eoi", 1'b1, 5'd1);
        do_ack(); irq = 32'h0; tick();
        wr(4'h3, 32'h0);
        rd(4'h4, "np_depth_end", 32'd0);
`endif

        // Reset while a request is outstanding
        irq = 32'h20; tick(); tick();
        chk_trap("rst_req", 1'b1, 5'd5);
        reset_n = 1'b0; tick();
        chk("rst_trap", {31'd0, trap}, 32'd0);
        chk("rst_vector", {27'd0, vector}, 32'd0);
        reset_n = 1'b1; irq = 32'h0;
        rd(4'h1, "rst_mask", 32'd0);
        rd(4'h2, "rst_edge", 32'd0);
        rd(4'h4, "rst_depth", 32'd0);
        rd(4'h0, "rst_pend", 32'd0);
        rd(4'h3, "rst_isv", 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/irq_sequencer.md
# irq_sequencer

Interrupt controller sitting between raw external IRQ lines and the tenyr core's trap input, alongside the external interrupt block on the same memory-mapped bus. It latches level- or edge-sensitive requests, masks them, picks the highest-priority candidate (lowest index wins), and presents a trap/vector/ack handshake to the core. It keeps a small in-service stack so higher-priority interrupts can pre-empt lower ones; end-of-interrupt (EOI) is signalled by a bus write.

## Interface
- `NEST_DEPTH`, default 8: in-service stack entries, from 1 to 32.
- `BASE`, default 28'hffffffe: match value for `addr[31:4]`.
- `clk`  in  1: clock.
- `reset_n`  in  1: reset, synchronous, active-low.
- `strobe`  in  1: bus cycle valid.
- `rw`  in  1: 1 = write, 0 = read.
- `addr`  in  32: bus address; `addr[3:0]` selects the register.
- `data`  inout  32: bus data; driven only while `strobe & ~rw`, otherwise 32'bz.
- `irq`  in  32: raw request lines.
- `trap`  out  1: interrupt request to the core; reset 0.
- `vector`  out  5: index of the requested interrupt; reset 0.
- `ack`  in  1: one-cycle pulse from the core, accepting the current `vector`.

## Operation
- **Register map**, selected when `strobe` is high and `addr[31:4]==BASE`. Unmapped offsets read 0 and ignore writes.
  - 0x0 PEND: read; write-1-to-clear, which affects edge bits only.
  - 0x1 MASK: read/write; 1 = enabled; reset 0.
  - 0x2 EDGE: read/write; 1 = rising-edge, 0 = level; reset 0.
  - 0x3 ISV: read returns `{depth!=0, 26'b0, top vector}`. Any write is an EOI and pops the stack; ignored when depth is 0.
  - 0x4 DEPTH: read-only, returns the 6-bit depth, zero-extended.
- **Input sampling**: `irq` is registered into `s`; the previous sample is held as `sp`.
- **Pending logic**:
  - Edge bit: set by `s & ~sp`; cleared by ack of that vector or by a PEND write-1-clear. If set and clear occur in the same cycle, set wins.
  - Level bit: PEND equals `s`; ack does not clear it.
- **Candidate set**: `PEND & MASK & above`.
  - `above` is all ones when depth is 0.
  - Otherwise `above` has only the bits with index strictly lower than the top vector.
- **Winner**: the lowest set index of the candidate set.
- **States** (2-bit): IDLE, REQ, BUSY_FULL.
  - IDLE → REQ when the candidate set is non-zero and depth < NEST_DEPTH. On that edge, `vector` is loaded with the winner and `trap` goes to 1.
  - IDLE → BUSY_FULL when depth == NEST_DEPTH; `trap` stays 0.
  - REQ with `ack`: push `vector`, depth+1, clear the edge pending bit, `trap` goes to 0, return to IDLE.
  - REQ without `ack`: `vector` re-tracks the current winner each cycle. If the candidate set becomes empty, `trap` goes to 0 and the state returns to IDLE.
  - BUSY_FULL → IDLE on EOI.
- **ack outside REQ**: ignored.
- **Simultaneous EOI and ack in REQ**: the pop is applied first, then the push. Net depth is unchanged and the top entry becomes the acked vector.
- **Bus reads**: `rdata` is registered on the edge where `strobe & ~rw` and the address matches. `data` drives `rdata`, so read data is valid from the cycle after the strobe edge.

## Timing
- Rising edge on `irq[n]` at edge k:
  - `s` updates at k+1.
  - PEND is set at k+2.
  - `trap` goes high at k+3, if the line is enabled and no stack limit applies.
- `ack` sampled at edge t: `trap` is low at t+1. A new trap can be raised no earlier than t+2.
- EOI write at edge t: depth and `above` update at t+1. A pending lower-priority interrupt can raise `trap` at t+2.
- A MASK write that clears the current winner's bit while in REQ: `trap` drops one edge later.
- Reset mid-operation clears the following on the next edge, with no pending or in-flight ack retained:
  - `trap`, `vector`, the stack, depth, PEND edge bits, MASK, EDGE, `s`, `sp`;
  - state returns to IDLE.

## Configuration
- `IRQ_SEQ_PREEMPT_EN` defined: behaviour as above, with nested pre-emption up to NEST_DEPTH.
- `IRQ_SEQ_PREEMPT_EN` undefined:
  - The effective stack limit is 1 and `above` is forced to 0 while depth is 1.
  - No trap is raised while an interrupt is in service, so PEND accumulates until EOI.
  - DEPTH reads only 0 or 1.

## Test plan
- **Basic edge trap**: MASK=0x1, EDGE=0x1, pulse `irq[0]` for 1 cycle, ack.
  - `trap` high 3 cycles after the pulse with `vector`=0.
  - After ack, PEND reads 0 and DEPTH reads 1.
  - EOI returns DEPTH to 0.
- **Priority and re-tracking**: MASK=0xFFFFFFFF, level `irq[5]` then `irq[2]` asserted before ack.
  - `vector` changes 5→2 with `trap` held high.
  - Ack pushes 2; ISV reads 0x80000002.
- **Pre-emption** (macro on): service vector 4, then assert `irq[1]`.
  - Second trap with `vector`=1 and DEPTH=2.
  - Asserting `irq[7]` during this time produces no trap until two EOIs.
- **Stack full**: NEST_DEPTH=2, acks for 6 then 3 taken, `irq[0]` asserted.
  - `trap` stays 0 and the state is BUSY_FULL.
  - EOI → `trap` rises with `vector`=0 two cycles later.
- **Boundaries**:
  - EOI at depth 0 → DEPTH stays 0.
  - PEND write-1-clear coincident with a new edge on the same bit → bit stays 1.
  - `reset_n` low during REQ → `trap`=0, `vector`=0, all registers read 0 next cycle.
- **No-preempt build** (macro off): service vector 4, assert `irq[1]`.
  - No trap; PEND bit 1 reads 1.
  - EOI → trap with `vector`=1.
